// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared fulladder cell computes a WIDTH-bit add LSB first, one bit per clock.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN, which adds the `sub` input port.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic S,
  output logic C
);

  assign S = a ^ b ^ cin;
  assign C = (a & b) | (cin & (a ^ b));

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Only the upper WIDTH-1 result bits need storage; the final MSB comes straight from S.
  logic [WIDTH-1:1] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             last_step;

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1, so the inverted operand and a forced carry-in are loaded.
  assign b_load = sub ? ~b : b;
  assign c_load = sub | cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  fulladder u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .S   (fa_s),
    .C   (fa_c)
  );

  assign res_next  = {fa_s, res_sr};
  assign last_step = (cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_step) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // sum/cout are only written on the final bit step, so partial results never appear on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr <= res_next[WIDTH-1:1];
          carry  <= fa_c;
          cnt    <= cnt + CNT_W'(1);
          if (last_step) begin
            sum  <= res_next;
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8).
// Define SERIAL_ADD_SUB_EN to also exercise the subtract mode.

module tb_serial_add_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub;
`endif
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives operands with start for exactly one edge, then scrambles operands to prove capture.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    a     = av;
    b     = bv;
    cin   = cv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
    cin   = ~cv;
  endtask

  // Called just after the accepting edge; returns done latency (-1 on timeout), busy cycles, and whether sum/cout held.
  task automatic waitDone(output int lat, output int busy_cnt, output bit held);
    logic [7:0] s0;
    logic       c0;
    s0 = sum;
    c0 = cout;
    lat = -1;
    busy_cnt = 0;
    held = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = n;
        break;
      end
      if (sum !== s0 || cout !== c0) held = 1'b0;
    end
  endtask

  int lat;
  int bcnt;
  bit held;
  int t1;
  int t2;
  int done_cnt;
  bit busy_after;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset and idle with start low.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("idle_busy", 32'(busy), 32'h0);
      checkOutput("idle_done", 32'(done), 32'h0);
      checkOutput("idle_sum",  32'(sum),  32'h00);
      checkOutput("idle_cout", 32'(cout), 32'h0);
    end

    // FF + 01: latency 9, busy 8 cycles.
    applyStimulus(8'hFF, 8'h01, 1'b0);
    waitDone(lat, bcnt, held);
    checkOutput("ff01_latency", 32'(lat), 32'd9);
    checkOutput("ff01_busycnt", 32'(bcnt), 32'd8);
    checkOutput("ff01_sum", 32'(sum), 32'h00);
    checkOutput("ff01_cout", 32'(cout), 32'h1);
    checkOutput("ff01_busy_in_done", 32'(busy), 32'h0);
    @(negedge clk);
    checkOutput("ff01_done_pulse", 32'(done), 32'h0);
    checkOutput("ff01_idle_busy", 32'(busy), 32'h0);
    checkOutput("ff01_sum_hold", 32'(sum), 32'h00);

    // A5 + 5A + 1 = 0x100.
    applyStimulus(8'hA5, 8'h5A, 1'b1);
    waitDone(lat, bcnt, held);
    checkOutput("a55a_latency", 32'(lat), 32'd9);
    checkOutput("a55a_sum", 32'(sum), 32'h00);
    checkOutput("a55a_cout", 32'(cout), 32'h1);

    // 12 + 34 = 46; previous result holds until done.
    applyStimulus(8'h12, 8'h34, 1'b0);
    waitDone(lat, bcnt, held);
    checkOutput("1234_held", 32'(held), 32'h1);
    checkOutput("1234_latency", 32'(lat), 32'd9);
    checkOutput("1234_sum", 32'(sum), 32'h46);
    checkOutput("1234_cout", 32'(cout), 32'h0);

    // 10 + 20 with start pulses at RUN cycles 3 and 8 carrying other operands.
    applyStimulus(8'h10, 8'h20, 1'b0);
    t1 = -1;
    done_cnt = 0;
    busy_after = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        t1 = n;
      end
      if (n >= 9 && busy) busy_after = 1'b1;
      if (n == 3 || n == 8) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    checkOutput("ignore_done_at", 32'(t1), 32'd9);
    checkOutput("ignore_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("ignore_no_restart", 32'(busy_after), 32'h0);
    checkOutput("ignore_sum", 32'(sum), 32'h30);
    checkOutput("ignore_cout", 32'(cout), 32'h0);

    // Start held high: back-to-back 03 + 04 spaced 10 cycles.
    @(negedge clk);
    a     = 8'h03;
    b     = 8'h04;
    cin   = 1'b0;
    start = 1'b1;
    t1 = -1;
    t2 = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        checkOutput("b2b_sum", 32'(sum), 32'h07);
        if (t1 < 0) begin
          t1 = n;
        end else begin
          t2 = n;
          start = 1'b0;
          break;
        end
      end
    end
    checkOutput("b2b_first", 32'(t1), 32'd9);
    checkOutput("b2b_spacing", 32'(t2 - t1), 32'd10);
    repeat (2) @(negedge clk);
    checkOutput("b2b_stopped", 32'(busy), 32'h0);

    // Reset in the 4th RUN cycle aborts with no done.
    applyStimulus(8'hFF, 8'hFF, 1'b0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_done", 32'(done), 32'h0);
    checkOutput("abort_sum", 32'(sum), 32'h00);
    checkOutput("abort_cout", 32'(cout), 32'h0);
    done_cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
    applyStimulus(8'h0F, 8'h01, 1'b0);
    waitDone(lat, bcnt, held);
    checkOutput("fresh_latency", 32'(lat), 32'd9);
    checkOutput("fresh_sum", 32'(sum), 32'h10);
    checkOutput("fresh_cout", 32'(cout), 32'h0);

    // rst and start on the same edge: start dropped.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h01;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("rststart_busy", 32'(busy), 32'h0);
    checkOutput("rststart_sum", 32'(sum), 32'h00);
    @(negedge clk);
    checkOutput("rststart_busy2", 32'(busy), 32'h0);

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    applyStimulus(8'h05, 8'h07, 1'b0);
    waitDone(lat, bcnt, held);
    checkOutput("sub_0507_sum", 32'(sum), 32'hFE);
    checkOutput("sub_0507_cout", 32'(cout), 32'h0);
    applyStimulus(8'h07, 8'h05, 1'b0);
    waitDone(lat, bcnt, held);
    checkOutput("sub_0705_sum", 32'(sum), 32'h02);
    checkOutput("sub_0705_cout", 32'(cout), 32'h1);
    sub = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder sequencer. It time-shares one instance of the team's 1-bit `fulladder` cell across a WIDTH-bit add, processing one bit per clock, LSB first, with a registered carry loop. It sits between a requester issuing `start`/operands and any consumer of the registered `sum`/`cout` result. It trades WIDTH cycles of latency for a single full-adder's area.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  operand A; captured on accepted start.
- `b`  in  WIDTH  operand B; captured on accepted start.
- `cin`  in  1  carry-in; captured on accepted start.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; result valid.
- `sum`  out  WIDTH  registered result; holds until the next completion.
- `cout`  out  1  registered final carry; holds until the next completion.

## Operation
- The block instantiates exactly one `fulladder` (ports `a`, `b`, `cin`, `S`, `C`). All arithmetic goes through it; there are no `+` operators on operands.
- Internal state:
  - A/B shift registers (WIDTH each).
  - Result shift register (WIDTH).
  - Carry flop.
  - Bit counter, $clog2(WIDTH) bits.
- FSM states:
  - IDLE: `start` = 1 captures `a`, `b`, `cin` into the shift registers and carry flop, clears the counter, and goes to RUN. `start` = 0 stays in IDLE.
  - RUN: the full adder sees A[0], B[0], and the carry flop. Each edge does the following:
    - shifts `S` into the result MSB and shifts the result register right;
    - shifts A and B right;
    - loads `C` into the carry flop;
    - increments the counter.
  - RUN exit: on the edge where counter == WIDTH-1, load `sum` from the completed result and `cout` from `C`, then go to DONE.
  - DONE: `done` = 1 for exactly one cycle, then return to IDLE unconditionally.
- `start` is ignored in RUN and DONE. It is not queued.
- `a`, `b`, and `cin` may change freely after the accepting edge.
- Result is (a + b + cin) mod 2^WIDTH. `cout` is bit WIDTH of the true sum.
- `sum` and `cout` change only on the edge entering DONE. Intermediate bits are never visible on `sum`.

## Timing
- Reset values: `busy` = 0, `done` = 0, `sum` = 0, `cout` = 0. The FSM enters IDLE, and the counter, shift registers, and carry flop clear to 0.
- Let E0 be the accepting edge.
  - `busy` rises after E0.
  - The RUN bit steps occur at E1..E_WIDTH.
  - `sum`, `cout`, and `done` are valid in the cycle after E_WIDTH; `busy` is low in that same cycle.
  - IDLE resumes after E_WIDTH+1.
- Latency from start to done is WIDTH+1 cycles.
- Maximum throughput is one add per WIDTH+2 cycles.
- The earliest next accepting edge is E_WIDTH+2, which requires `start` to be high in the first IDLE cycle.
- Reset mid-operation: `rst` at any edge aborts. The FSM goes to IDLE, `busy` and `done` go to 0, and `sum` and `cout` clear to 0. No `done` is emitted for the aborted operation.
- If `rst` and `start` are high at the same edge, `rst` wins and the start is dropped.

## Configuration
- `SERIAL_ADD_SUB_EN` defined:
  - Adds input port `sub` (1 bit), captured with the operands.
  - When `sub` = 1, the B shift register loads ~`b` and the carry flop loads 1, ignoring `cin`. The result is a - b in two's complement.
  - `cout` = 1 means no borrow.
- `SERIAL_ADD_SUB_EN` undefined: the `sub` port does not exist and the block is add-only.

## Test plan
- Reset, then idle with `start` low for 5 cycles: `busy` = 0, `done` = 0, `sum` = 8'h00, `cout` = 0 throughout.
- WIDTH=8, `a` = 8'hFF, `b` = 8'h01, `cin` = 0: `done` occurs exactly 9 cycles after the accepting edge with `sum` = 8'h00, `cout` = 1, and `busy` is high for exactly 8 cycles.
- `a` = 8'hA5, `b` = 8'h5A, `cin` = 1: `sum` = 8'h00, `cout` = 1. Then `a` = 8'h12, `b` = 8'h34, `cin` = 0: `sum` = 8'h46, `cout` = 0, and the previous result holds on `sum` until the new `done`.
- Pulse `start` with new operands at cycles 3 and 8 of RUN: no effect, and the result equals the original operation. `start` held high continuously gives back-to-back adds spaced 10 cycles apart.
- Assert `rst` at the 4th RUN cycle: `busy` = 0 next cycle, no `done`, `sum` = 8'h00. A fresh start of 8'h0F + 8'h01 then gives `sum` = 8'h10.
- With `SERIAL_ADD_SUB_EN`:
  - `sub` = 1, `a` = 8'h05, `b` = 8'h07 gives `sum` = 8'hFE, `cout` = 0.
  - `a` = 8'h07, `b` = 8'h05 gives `sum` = 8'h02, `cout` = 1.
